// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
// Registered RV32I/RV64I immediate generator with a 2-entry output FIFO.
// Decodes the immediate, a format tag and an illegal-opcode flag from each
// accepted instruction and carries a sideband tag (normally the PC) with it.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   flush             : synchronous; empties the buffer, drops the offered input
//   in_valid/in_ready : input handshake (in_ready depends on registered state only)
//   in_instr, in_tag  : instruction word and sideband tag
//   out_valid/out_ready : output handshake for the head entry
//   out_imm, out_fmt, out_illegal, out_tag : head entry (all 0 when out_valid=0)
`timescale 1ns/1ps

module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_OPIMM    = 7'b0010011;
    localparam logic [6:0] OP_OPIMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_OP32     = 7'b0111011;
    localparam logic [6:0] OP_FENCE    = 7'b0001111;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6,
        FMT_ILL  = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        fmt_e             fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    // Every immediate is first assembled as a 32-bit value already sign- or
    // zero-extended to 32 bits; widening to XLEN then only needs a cast.
    function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    function automatic logic [XLEN-1:0] zext(input logic [31:0] v);
        return XLEN'(v);
    endfunction

    // ------------------------------------------------------------------
    // Combinational decode of the offered instruction
    // ------------------------------------------------------------------
    entry_t     dec;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_shift;

    assign opcode   = in_instr[6:0];
    assign funct3   = in_instr[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    // NOTE: every field gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        dec.imm     = '0;
        dec.fmt     = FMT_NONE;
        dec.illegal = 1'b0;
        dec.tag     = in_tag;
        unique case (opcode)
            OP_LUI, OP_AUIPC: begin
                dec.fmt = FMT_U;
                dec.imm = sext({in_instr[31:12], 12'b0});
            end
            OP_JAL: begin
                dec.fmt = FMT_J;
                dec.imm = sext({{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                in_instr[20], in_instr[30:21], 1'b0});
            end
            OP_JALR, OP_LOAD: begin
                dec.fmt = FMT_I;
                dec.imm = sext({{20{in_instr[31]}}, in_instr[31:20]});
            end
            OP_OPIMM: begin
                dec.fmt = FMT_I;
                if (!is_shift)
                    dec.imm = sext({{20{in_instr[31]}}, in_instr[31:20]});
                else if (XLEN == 64)
                    dec.imm = zext({26'b0, in_instr[25:20]});
                else
                    dec.imm = zext({27'b0, in_instr[24:20]});
            end
            OP_OPIMM32: begin
                // Word shifts only ever take a 5-bit shamt.
                if (XLEN == 64) begin
                    dec.fmt = FMT_I;
                    if (is_shift)
                        dec.imm = zext({27'b0, in_instr[24:20]});
                    else
                        dec.imm = sext({{20{in_instr[31]}}, in_instr[31:20]});
                end else begin
                    dec.fmt     = FMT_ILL;
                    dec.illegal = 1'b1;
                end
            end
            OP_STORE: begin
                dec.fmt = FMT_S;
                dec.imm = sext({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
            end
            OP_BRANCH: begin
                dec.fmt = FMT_B;
                dec.imm = sext({{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                in_instr[30:25], in_instr[11:8], 1'b0});
            end
            OP_SYSTEM: begin
                if (funct3[2]) begin
                    dec.fmt = FMT_Z;
                    dec.imm = zext({27'b0, in_instr[19:15]});
                end
            end
            OP_OP, OP_FENCE: begin
                dec.fmt = FMT_NONE;
            end
            OP_OP32: begin
                if (XLEN != 64) begin
                    dec.fmt     = FMT_ILL;
                    dec.illegal = 1'b1;
                end
            end
            default: begin
                dec.fmt     = FMT_ILL;
                dec.illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // 2-entry FIFO
    // ------------------------------------------------------------------
    entry_t     mem [2];
    logic [1:0] count;
    logic       wr_ptr;
    logic       rd_ptr;
    logic       push;
    logic       pop;
    entry_t     head;

    assign in_ready  = (count < 2'd2) && !rst;
    assign out_valid = (count != 2'd0);
    // An input offered during flush is dropped; a pop during flush is moot.
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // NOTE: sequential state is updated with non-blocking assignments so
    // every register sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    // NOTE: the storage array is deliberately not reset; the outputs are
    // masked by out_valid, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dec;
    end

    assign head        = mem[rd_ptr];
    assign out_imm     = out_valid ? head.imm     : '0;
    assign out_fmt     = out_valid ? head.fmt     : FMT_NONE;
    assign out_illegal = out_valid ? head.illegal : 1'b0;
    assign out_tag     = out_valid ? head.tag     : '0;

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, parametrised immediate generator for all RV32I/RV64I formats: U, I, S, B, J, shift-immediate and CSR zimm.
- Sits between fetch/decode and the register-read stage.
- Accepts one instruction per cycle over a valid/ready handshake and buffers results in a 2-entry FIFO.
- Produces the sign-extended immediate plus a format tag and an illegal-opcode flag, with a passthrough tag (typically the PC).

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
TAG_W, 32, width of the sideband tag carried alongside each instruction.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
flush  in  1  synchronous; empties the buffer.
in_valid  in  1  instruction present.
in_ready  out  1  block can accept this cycle.
in_instr  in  32  instruction word.
in_tag  in  TAG_W  sideband tag (PC).
out_valid  out  1  head entry valid.
out_ready  in  1  consumer accepts the head entry.
out_imm  out  XLEN  immediate.
out_fmt  out  3  format: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (zimm), 7 illegal.
out_illegal  out  1  opcode not recognised.
out_tag  out  TAG_W  tag of the head entry.

Behaviour:
- Decode by opcode = instr[6:0]. All sign-extension is from instr[31] to XLEN.
  - 0110111 LUI / 0010111 AUIPC: U; imm = {instr[31:12], 12'b0}, sign-extended.
  - 1101111 JAL: J; imm = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - 1100111 JALR, 0000011 LOAD: I; imm = instr[31:20].
  - 0010011 OP-IMM: I.
    - funct3 = 001 or 101 (shift): imm = shamt zero-extended; shamt = instr[24:20] when XLEN=32, instr[25:20] when XLEN=64. funct6/funct7 bits are excluded.
    - Otherwise: imm = instr[31:20].
  - 0011011 OP-IMM-32: XLEN=64 only, decoded as OP-IMM with a 5-bit shamt; illegal when XLEN=32.
  - 0100011 STORE: S; imm = {instr[31:25], instr[11:7]}.
  - 1100011 BRANCH: B; imm = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - 1110011 SYSTEM:
    - funct3[2] = 1: Z; imm = instr[19:15] zero-extended.
    - Otherwise: fmt 0, imm 0.
  - 0110011 OP, 0111011 OP-32 (XLEN=64 only), 0001111 FENCE: fmt 0, imm 0.
  - Any other opcode: fmt 7, imm 0, out_illegal = 1. The entry is still delivered, never dropped.
- Decode is combinational on input; the result is written into the FIFO on the accept edge.
- Handshake:
  - Accept when in_valid & in_ready.
  - Pop when out_valid & out_ready.
  - in_ready = (count < 2) & ~rst. It depends only on registered state and never on out_ready.
  - Latency is exactly 1 cycle: an entry accepted at edge N is visible at the output after edge N with out_valid = 1.
  - Throughput is 1/cycle while out_ready stays high.
  - Push and pop in the same cycle: count unchanged, order preserved (FIFO, pointer wrap modulo 2).
- Outputs are driven from the head entry. When out_valid = 0: out_imm, out_fmt, out_illegal and out_tag are all 0.
- Outputs are stable while out_valid & ~out_ready (no change under backpressure).
- flush:
  - Next cycle count = 0 and out_valid = 0.
  - An input offered in the flush cycle is dropped even if in_ready = 1.
  - A pop in the flush cycle is irrelevant.
- rst (priority over flush):
  - Next cycle count = 0, pointers = 0, out_valid = 0, all data outputs 0.
  - in_ready = 0 while rst is high, 1 the cycle after.
  - Reset in the middle of a backpressured transfer discards all entries.
- When XLEN=32, bits above 31 do not exist. When XLEN=64, every format is sign-extended to 64 bits except shift and Z, which are zero-extended.

Test Plan:
- XLEN=32, addi 0xFFF00093, tag 0x100, out_ready=1 -> next cycle out_valid=1, imm 0xFFFFFFFF, fmt 1, tag 0x100; out_valid=0 the cycle after.
- Back-to-back sw 0xFE112E23, beq 0xFE000CE3, jal 0x001000EF, lui 0x123450B7, srai 0x4030D093, csrrwi 0x0052D0F3 -> imm 0xFFFFFFFC/S, 0xFFFFFFF8/B, 0x00000800/J, 0x12345000/U, 0x00000003/I, 0x00000005/Z, one per cycle, in order.
- Opcode 0x0000007F -> fmt 7, out_illegal=1, imm 0; the entry is delivered normally.
- XLEN=64: lui 0x800000B7 -> imm 0xFFFFFFFF80000000; slli 0x03F09093 -> imm 0x3F; addiw 0xFFF0809B -> imm 0xFFFFFFFFFFFFFFFF.
- Backpressure: out_ready=0, in_valid held for 3 instructions -> first two accepted, in_ready=0 on the 3rd, outputs stable; out_ready=1 -> entries 1, 2, 3 delivered in order, no loss or duplicate.
- Two entries buffered, flush=1 together with in_valid=1 -> next cycle out_valid=0, count 0, offered instruction dropped. Repeat with rst=1 -> same result, plus in_ready=0 during the rst cycle.
